// File: rtl/div_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
// The master modport is the EX side; the slave modport is the divider itself.
interface div_unit_if #(
   parameter int unsigned DATA_W = 32
);
   logic                  start_i;
   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  stallreq_for_ex;

   modport master (
      output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
      input  result_o, ready_o, stallreq_for_ex
   );

   modport slave (
      input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
      output result_o, ready_o, stallreq_for_ex
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// Produces {remainder, quotient} and stalls EX while a divide is in flight.
module div_unit #(
   parameter int unsigned DATA_W = 32
) (
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam int unsigned RES_W = 2 * DATA_W;

   typedef enum logic [1:0] {FREE, ZERO, ON, END} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   dvd;
   logic [DATA_W-1:0]   dsr;
   logic [DATA_W-1:0]   rem;
   logic                neg_q;
   logic                neg_r;
   logic [RES_W-1:0]    result;
   logic                ready;

   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   abs_a;
   logic [DATA_W-1:0]   abs_b;
   logic [DATA_W:0]     partial;
   logic [DATA_W:0]     diff;
   logic                q_bit;
   logic [DATA_W-1:0]   rem_nxt;
   logic [DATA_W-1:0]   quo_nxt;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   quo_fix;

   // Magnitudes of the operands; |0x80..0| wraps to itself, which is correct unsigned.
   always_comb begin
      a_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
      b_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
      abs_a = a_neg ? DATA_W'(-bus.opdata1_i) : bus.opdata1_i;
      abs_b = b_neg ? DATA_W'(-bus.opdata2_i) : bus.opdata2_i;
   end

   // One restoring step; dvd shifts dividend bits out the top and quotient bits in.
   always_comb begin
      partial = {rem, dvd[DATA_W-1]};
      diff    = partial - {1'b0, dsr};
      q_bit   = ~diff[DATA_W];
      rem_nxt = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
      quo_nxt = {dvd[DATA_W-2:0], q_bit};
      quo_fix = neg_q ? DATA_W'(-quo_nxt) : quo_nxt;
      rem_fix = neg_r ? DATA_W'(-rem_nxt) : rem_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= FREE;
         cnt    <= '0;
         dvd    <= '0;
         dsr    <= '0;
         rem    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               if (bus.start_i && !bus.annul_i) begin
                  if (bus.opdata2_i == '0) begin
                     state <= ZERO;
                  end else begin
                     state <= ON;
                     dvd   <= abs_a;
                     dsr   <= abs_b;
                     rem   <= '0;
                     neg_q <= a_neg ^ b_neg;
                     neg_r <= a_neg;
                     cnt   <= '0;
                  end
               end
            end
            ZERO: begin
               if (bus.annul_i) begin
                  state <= FREE;
               end else begin
                  state  <= END;
                  result <= '0;
                  ready  <= 1'b1;
               end
            end
            ON: begin
               if (bus.annul_i) begin
                  state <= FREE;
               end else begin
                  dvd <= quo_nxt;
                  rem <= rem_nxt;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_W - 1)) begin
                     state  <= END;
                     result <= {rem_fix, quo_fix};
                     ready  <= 1'b1;
                  end
               end
            end
            END: begin
               state <= FREE;
               ready <= 1'b0;
            end
            default: state <= FREE;
         endcase
      end
   end

   assign bus.result_o        = result;
   assign bus.ready_o         = ready;
   assign bus.stallreq_for_ex = bus.start_i & ~ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic, latency, stall length, divide-by-zero,
// back-to-back issue, annul and asynchronous reset mid-divide.
module tb_div_unit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   div_unit_if #(.DATA_W(32)) bus ();

   div_unit #(.DATA_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one divide and check result, start-to-ready latency and stall length.
   task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input int exp_stall, input int scr_at,
                         input bit hold);
      int n;
      int st;
      bit done;
      @(negedge clk);
      bus.start_i      = 1'b1;
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      n    = 0;
      st   = 0;
      done = 1'b0;
      #1;
      if (bus.stallreq_for_ex) st++;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (n == scr_at) begin
            bus.signed_div_i = ~sgn;
            bus.opdata1_i    = ~a;
            bus.opdata2_i    = ~b;
         end
         if (bus.ready_o) done = 1'b1;
         else if (bus.stallreq_for_ex) st++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s timeout: no ready_o within %0d cycles", name, n);
      end
      total++;
      if (n !== exp_lat) begin
         bad++;
         $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
      end
      total++;
      if (bus.result_o !== exp_res) begin
         bad++;
         $display("FAIL %s result: got %h expected %h", name, bus.result_o, exp_res);
      end
      total++;
      if (st !== exp_stall) begin
         bad++;
         $display("FAIL %s stall: got %0d expected %0d", name, st, exp_stall);
      end
      if (!hold) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         @(posedge clk);
         #1;
         total++;
         if (bus.ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_pulse: got %b expected 0", name, bus.ready_o);
         end
      end
   endtask

   task automatic test_reset();
      total++;
      if (bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL reset_result: got %h expected 0", bus.result_o);
      end
      total++;
      if (bus.ready_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
      end
      total++;
      if (bus.stallreq_for_ex !== 1'b0) begin
         bad++;
         $display("FAIL reset_stall_idle: got %b expected 0", bus.stallreq_for_ex);
      end
      bus.start_i = 1'b1;
      #1;
      total++;
      if (bus.stallreq_for_ex !== 1'b1) begin
         bad++;
         $display("FAIL reset_stall_follow: got %b expected 1", bus.stallreq_for_ex);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_arith();
      do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, 1, 1'b0);
      do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, 1, 1'b0);
      do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 33, 1, 1'b0);
      do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 33, 1, 1'b0);
      do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 33, 1, 1'b0);
      do_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 33, 33, 1, 1'b0);
      do_div("divu_big", 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFF8, 32'd0}, 33, 33, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_div("div_zero", 1'b0, 32'd55, 32'd0, 64'h0, 2, 2, 1, 1'b1);
      do_div("b2b_9_4", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 34, 33, 2, 1'b0);
   endtask

   task automatic test_annul();
      bit seen;
      @(negedge clk);
      bus.start_i      = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL annul_ready: got ready_o=1 expected none");
      end
      total++;
      if (bus.result_o !== {32'd1, 32'd2}) begin
         bad++;
         $display("FAIL annul_result: got %h expected %h", bus.result_o, {32'd1, 32'd2});
      end
      do_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 33, 1, 1'b0);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.start_i      = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd12345;
      bus.opdata2_i    = 32'd10;
      repeat (21) @(posedge clk);
      #3;
      rst         = 1'b0;
      bus.start_i = 1'b0;
      #1;
      total++;
      if (bus.result_o !== 64'h0) begin
         bad++;
         $display("FAIL arst_result: got %h expected 0", bus.result_o);
      end
      total++;
      if (bus.ready_o !== 1'b0) begin
         bad++;
         $display("FAIL arst_ready: got %b expected 0", bus.ready_o);
      end
      total++;
      if (bus.stallreq_for_ex !== 1'b0) begin
         bad++;
         $display("FAIL arst_stall: got %b expected 0", bus.stallreq_for_ex);
      end
      @(negedge clk);
      rst = 1'b1;
      do_div("after_arst", 1'b0, 32'd12345, 32'd10, {32'd5, 32'd1234}, 33, 33, 1, 1'b0);
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      rst              = 1'b0;
      bus.start_i      = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.annul_i      = 1'b0;
      #12;
      test_reset();
      test_arith();
      test_back_to_back();
      test_annul();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit radix-2 restoring divider for the EX stage of the 5-stage pipeline. It serves DIV/DIVU, producing {remainder, quotient} for the HI/LO write path. While a divide is in flight it raises `stallreq_for_ex` to the stall controller, so that PC, IF, ID and EX hold. One divide occupies the unit for 33 cycles; a divide by zero occupies it for 2 cycles.

## Interface
Parameters:
- `DATA_W`, 32: operand width. The iteration count equals `DATA_W`; only 32 is required to be verified.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start_i`  in  1  EX requests a divide. Held high by EX until it samples `ready_o`=1.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i`
- `opdata1_i`  in  32  dividend; sampled with `start_i`
- `opdata2_i`  in  32  divisor; sampled with `start_i`
- `annul_i`  in  1  cancel: flush/exception kills the in-flight divide
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}, registered
- `ready_o`  out  1  result valid, one-cycle pulse, registered
- `stallreq_for_ex`  out  1  `start_i & ~ready_o` (combinational from registered `ready_o`)

## Operation
- States: FREE, ZERO, ON, END. Reset state is FREE.
- FREE:
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON. Latch |dividend|, |divisor|, the sign flags and the op type; clear `cnt`.
  - `start_i`=1, `annul_i`=0, divisor=0 → ZERO.
  - Otherwise stay in FREE.
- ON: one restoring step per cycle.
  - Form the 33-bit trial `{rem[31:0], q_msb} - {1'b0, divisor}`.
  - If non-negative: remainder ← difference and shift in 1; else shift in 0.
  - `cnt` increments each cycle. On the 32nd step (`cnt`=31) → END. At the same edge, register the sign-corrected result into `result_o` and set `ready_o`=1.
- Sign rules (signed only):
  - quotient negated iff dividend sign ≠ divisor sign.
  - remainder takes the dividend's sign.
  - Unsigned: no correction.
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. This is the natural wrap; no trap.
- ZERO → END unconditionally. At that edge `result_o` ← 64'h0 and `ready_o`=1. The architectural result is undefined, but zero is the required value.
- END → FREE unconditionally, with `ready_o` ← 0.
  - `result_o` holds until the next completion.
  - If `start_i` is still high in FREE (back-to-back divide, or EX held by a downstream stall), a new divide begins. Recomputation is harmless.
- `annul_i`=1 in ON or ZERO → FREE at the next edge. `ready_o` stays 0 and `result_o` is unchanged. In END it has no effect; the pulse completes.
- Arithmetic: the absolute value of 0x80000000 is 0x80000000 when treated as unsigned 32-bit. The datapath is unsigned throughout, so this needs no special case.

## Timing
- Reset (`rst`=0, asynchronous): state FREE, `cnt`=0, `result_o`=64'h0, `ready_o`=0. `stallreq_for_ex` then follows `start_i`.
- Normal divide, with `start_i` first sampled at edge E0:
  - ON during E1..E32; the 32nd step is at E32.
  - `ready_o`=1 in the cycle after E32.
  - `stallreq_for_ex` is high from the cycle before E0 through the cycle before E32: 33 stall cycles.
- Divide by zero: ZERO after E0, `ready_o`=1 after E1; 2 stall cycles.
- `ready_o` is never high for more than one consecutive cycle unless `start_i` is re-asserted and a new divide completes.
- Reset asserted mid-ON: immediate return to the reset values. No partial result is ever exposed.
- Operand changes on `opdata*_i` after E0 are ignored.

## Test plan
- DIVU 100 / 7:
  - `ready_o` high exactly 33 cycles after the start edge.
  - `result_o` = {32'd2, 32'd14}.
  - `stallreq_for_ex` high for exactly 33 cycles.
- DIV −7 / 2 → {32'hFFFFFFFF, 32'hFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0, 32'h80000000}.
- DIVU 0xFFFFFFFF / 1 → {0, 32'hFFFFFFFF}.
- Divisor 0:
  - `ready_o` high 2 cycles after start; `result_o`=0.
  - Back-to-back DIVU 9/4 immediately afterwards (`start_i` held) → {1, 2} after a further 33 cycles.
- Interruption:
  - `annul_i` pulsed at ON step 10: FREE next cycle, no `ready_o`, `result_o` keeps its previous value.
  - `rst` pulled low at step 20: all outputs 0 asynchronously. A restart then completes correctly.
